serial_subtractor: RTL and testbench

Bit-serial WIDTH-bit subtractor built around a single full-subtractor cell plus a registered borrow. It accepts two parallel operands and a borrow-in on a start pulse. It processes one bit per clock, LSB first, and presents the parallel difference and final borrow-out with a one-cycle done pulse. It is the sequential stage that consumes the full subtractor cell, reusing it WIDTH times instead of instantiating a ripple chain.

---
 rtl/serial_subtractor_if.sv | 24 ++
 rtl/serial_subtractor.sv | 82 ++++++++
 tb/tb_serial_subtractor.sv | 278 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/serial_subtractor_if.sv
// Handshake/data bundle for the bit-serial subtractor.
// The master drives the operands and start; the slave returns status and result.
interface serial_subtractor_if #(
    parameter int WIDTH = 8
);
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             bin;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] diff;
    logic             bout;

    modport master (
        output start, a, b, bin,
        input  busy, done, diff, bout
    );

    modport slave (
        input  start, a, b, bin,
        output busy, done, diff, bout
    );
endinterface

// File: rtl/serial_subtractor.sv
// Bit-serial WIDTH-bit subtractor: one full-subtractor cell reused WIDTH times,
// LSB first, with a registered borrow. Result is {bout, diff} = a - b - bin.
module serial_subtractor #(
    parameter int WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    serial_subtractor_if.slave   bus
);
    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] SHIFT = 2'd1;
    localparam logic [1:0] DONE  = 2'd2;

    logic [1:0]       state;
    logic [WIDTH-1:0] ra;
    logic [WIDTH-1:0] rb;
    logic [WIDTH-1:0] diff_r;
    logic             br;
    logic             bout_r;
    logic [CW-1:0]    cnt;

    logic d;
    logic bo;
    logic last;
    logic accept;

    // Full-subtractor cell on the current LSBs plus control decode.
    always_comb begin
        d      = ra[0] ^ rb[0] ^ br;
        bo     = (~ra[0] & rb[0]) | (~(ra[0] ^ rb[0]) & br);
        last   = (cnt == CW'(WIDTH - 1));
        accept = bus.start && ((state == IDLE) || (state == DONE));
    end

    // Sequencer and datapath: capture on accepted start, shift one bit per clock.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            ra     <= '0;
            rb     <= '0;
            diff_r <= '0;
            br     <= 1'b0;
            bout_r <= 1'b0;
            cnt    <= '0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (accept) begin
                        ra     <= bus.a;
                        rb     <= bus.b;
                        br     <= bus.bin;
                        diff_r <= '0;
                        cnt    <= '0;
                        state  <= SHIFT;
                    end else if (state == DONE) begin
                        state <= IDLE;
                    end
                end
                SHIFT: begin
                    diff_r <= {d, diff_r[WIDTH-1:1]};
                    ra     <= {1'b0, ra[WIDTH-1:1]};
                    rb     <= {1'b0, rb[WIDTH-1:1]};
                    br     <= bo;
                    cnt    <= cnt + CW'(1);
                    if (last) begin
                        bout_r <= bo;
                        state  <= DONE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Status flags decode straight from the state register, so both are registered.
    assign bus.busy = (state == SHIFT);
    assign bus.done = (state == DONE);
    assign bus.diff = diff_r;
    assign bus.bout = bout_r;
endmodule

// File: tb/tb_serial_subtractor.sv
// Directed bench for serial_subtractor at WIDTH=8 and an exhaustive WIDTH=2 sweep.
module tb_serial_subtractor;
    logic clk;
    logic rst_n;
    int   checks;
    int   errors;

    serial_subtractor_if #(.WIDTH(8)) bus8 ();
    serial_subtractor_if #(.WIDTH(2)) bus2 ();

    serial_subtractor #(.WIDTH(8)) dut8 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus8)
    );

    serial_subtractor #(.WIDTH(2)) dut2 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Advance until the 8-bit done is seen (bounded); n = edges waited, bc = busy cycles seen.
    task automatic wait_done8(output int n, output int bc);
        n  = 0;
        bc = 0;
        while (bus8.done !== 1'b1 && n < 40) begin
            if (bus8.busy === 1'b1) bc++;
            tick();
            n++;
        end
    endtask

    task automatic wait_done2(output int n);
        n = 0;
        while (bus2.done !== 1'b1 && n < 20) begin
            tick();
            n++;
        end
    endtask

    task automatic drive8(input logic [7:0] a, input logic [7:0] b, input logic bin);
        bus8.start = 1'b1;
        bus8.a     = a;
        bus8.b     = b;
        bus8.bin   = bin;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        bus8.start = 1'b0; bus8.a = '0; bus8.b = '0; bus8.bin = 1'b0;
        bus2.start = 1'b0; bus2.a = '0; bus2.b = '0; bus2.bin = 1'b0;
        #3;
        checks++;
        if ({bus8.busy, bus8.done, bus8.diff, bus8.bout} !== 11'h000) begin
            errors++;
            $display("FAIL reset_outputs: got busy=%b done=%b diff=%h bout=%b, want all 0",
                     bus8.busy, bus8.done, bus8.diff, bus8.bout);
        end
        #9;
        rst_n = 1'b1;
        tick();
        checks++;
        if (bus8.busy !== 1'b0 || bus8.done !== 1'b0) begin
            errors++;
            $display("FAIL reset_idle: got busy=%b done=%b, want 0 0", bus8.busy, bus8.done);
        end
    endtask

    task automatic test_basic();
        int n, bc;
        drive8(8'h5A, 8'h3C, 1'b0);
        tick();
        bus8.start = 1'b0;
        wait_done8(n, bc);
        checks++;
        if (n != 8) begin
            errors++;
            $display("FAIL basic_latency: done %0d edges after start edge, want 8", n);
        end
        checks++;
        if (bc != 8) begin
            errors++;
            $display("FAIL basic_busy_cycles: got %0d, want 8", bc);
        end
        checks++;
        if (bus8.diff !== 8'h1E || bus8.bout !== 1'b0 || bus8.busy !== 1'b0) begin
            errors++;
            $display("FAIL basic_result: got diff=%h bout=%b busy=%b, want 1e 0 0",
                     bus8.diff, bus8.bout, bus8.busy);
        end
        tick();
        checks++;
        if (bus8.done !== 1'b0) begin
            errors++;
            $display("FAIL basic_done_pulse: done=%b one cycle later, want 0", bus8.done);
        end
        repeat (3) tick();
        checks++;
        if (bus8.diff !== 8'h1E || bus8.bout !== 1'b0) begin
            errors++;
            $display("FAIL basic_hold: got diff=%h bout=%b in idle, want 1e 0", bus8.diff, bus8.bout);
        end
    endtask

    task automatic test_borrow();
        int n, bc;
        drive8(8'h00, 8'h01, 1'b0);
        tick();
        bus8.start = 1'b0;
        wait_done8(n, bc);
        checks++;
        if (n != 8 || bus8.diff !== 8'hFF || bus8.bout !== 1'b1) begin
            errors++;
            $display("FAIL borrow_0_minus_1: got n=%0d diff=%h bout=%b, want 8 ff 1", n, bus8.diff, bus8.bout);
        end
        tick();
        drive8(8'hFF, 8'hFF, 1'b1);
        tick();
        bus8.start = 1'b0;
        wait_done8(n, bc);
        checks++;
        if (n != 8 || bus8.diff !== 8'hFF || bus8.bout !== 1'b1) begin
            errors++;
            $display("FAIL borrow_ff_ff_bin: got n=%0d diff=%h bout=%b, want 8 ff 1", n, bus8.diff, bus8.bout);
        end
        tick();
    endtask

    task automatic test_back_to_back();
        int n, bc;
        drive8(8'h80, 8'h00, 1'b1);
        tick();
        // start stays high; these operands change mid-flight and are picked up in DONE
        bus8.a = 8'h10; bus8.b = 8'h01; bus8.bin = 1'b0;
        wait_done8(n, bc);
        checks++;
        if (n != 8 || bus8.diff !== 8'h7F || bus8.bout !== 1'b0) begin
            errors++;
            $display("FAIL b2b_first: got n=%0d diff=%h bout=%b, want 8 7f 0", n, bus8.diff, bus8.bout);
        end
        tick();
        bus8.start = 1'b0;
        checks++;
        if (bus8.busy !== 1'b1 || bus8.done !== 1'b0) begin
            errors++;
            $display("FAIL b2b_restart: got busy=%b done=%b after done cycle, want 1 0", bus8.busy, bus8.done);
        end
        wait_done8(n, bc);
        checks++;
        if (n != 8 || bus8.diff !== 8'h0F || bus8.bout !== 1'b0) begin
            errors++;
            $display("FAIL b2b_second: got n=%0d diff=%h bout=%b, want 8 0f 0", n, bus8.diff, bus8.bout);
        end
        tick();
    endtask

    task automatic test_ignored_start();
        int n, bc, dones;
        drive8(8'h33, 8'h11, 1'b0);
        tick();
        bus8.start = 1'b0;
        tick();
        tick();
        drive8(8'hFF, 8'h00, 1'b0);
        tick();
        bus8.start = 1'b0;
        wait_done8(n, bc);
        checks++;
        if (n + 3 != 8 || bus8.diff !== 8'h22 || bus8.bout !== 1'b0) begin
            errors++;
            $display("FAIL ignored_start_result: got edges=%0d diff=%h bout=%b, want 8 22 0",
                     n + 3, bus8.diff, bus8.bout);
        end
        dones = 0;
        repeat (12) begin
            tick();
            if (bus8.done === 1'b1) dones++;
        end
        checks++;
        if (dones != 0 || bus8.busy !== 1'b0) begin
            errors++;
            $display("FAIL ignored_start_single_done: got extra dones=%0d busy=%b, want 0 0", dones, bus8.busy);
        end
    endtask

    task automatic test_reset_mid();
        int n, bc, dones;
        drive8(8'h5A, 8'h3C, 1'b0);
        tick();
        bus8.start = 1'b0;
        repeat (4) tick();
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({bus8.busy, bus8.done, bus8.diff, bus8.bout} !== 11'h000) begin
            errors++;
            $display("FAIL midreset_clear: got busy=%b done=%b diff=%h bout=%b, want all 0",
                     bus8.busy, bus8.done, bus8.diff, bus8.bout);
        end
        dones = 0;
        repeat (3) begin
            tick();
            if (bus8.done === 1'b1) dones++;
        end
        rst_n = 1'b1;
        repeat (8) begin
            tick();
            if (bus8.done === 1'b1 || bus8.busy === 1'b1) dones++;
        end
        checks++;
        if (dones != 0) begin
            errors++;
            $display("FAIL midreset_no_done: got %0d active cycles after reset, want 0", dones);
        end
        drive8(8'hC3, 8'h5A, 1'b1);
        tick();
        bus8.start = 1'b0;
        wait_done8(n, bc);
        checks++;
        if (n != 8 || bus8.diff !== 8'h68 || bus8.bout !== 1'b0) begin
            errors++;
            $display("FAIL midreset_fresh_op: got n=%0d diff=%h bout=%b, want 8 68 0", n, bus8.diff, bus8.bout);
        end
        tick();
    endtask

    task automatic test_width2();
        int n;
        logic [4:0] v;
        logic [2:0] expv;
        for (int i = 0; i < 32; i++) begin
            v    = 5'(i);
            expv = {1'b0, v[4:3]} - {1'b0, v[2:1]} - {2'b00, v[0]};
            bus2.start = 1'b1;
            bus2.a     = v[4:3];
            bus2.b     = v[2:1];
            bus2.bin   = v[0];
            tick();
            bus2.start = 1'b0;
            wait_done2(n);
            checks++;
            if (n != 2 || {bus2.bout, bus2.diff} !== expv) begin
                errors++;
                $display("FAIL w2_case%0d: got n=%0d {bout,diff}=%b, want 2 %b", i, n, {bus2.bout, bus2.diff}, expv);
            end
            tick();
            checks++;
            if (bus2.done !== 1'b0) begin
                errors++;
                $display("FAIL w2_single_done%0d: done=%b after pulse, want 0", i, bus2.done);
            end
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_basic();
        test_borrow();
        test_back_to_back();
        test_ignored_start();
        test_reset_mid();
        test_width2();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
